// File: rtl/oreg_display_driver.sv
// OREG value -> 3-digit BCD (9-edge double-dabble) -> multiplexed 7-segment scan.
// Optional leading-zero blanking under `LEADING_ZERO_BLANK_EN; default build shows all digits.
module oreg_display_driver #(
  parameter int REFRESH_DIV    = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  o_in,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        valid
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [8:0]  last_val;
  logic        force_cnv;
  logic [20:0] sreg;
  logic [3:0]  iter;
  logic [20:0] adj;
  logic [20:0] shifted;
  logic [15:0] scan_cnt;
  logic [1:0]  digit;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  seg_hi;
  logic [2:0]  an_hi;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0111111;
      4'd1:    seg_decode = 7'b0000110;
      4'd2:    seg_decode = 7'b1011011;
      4'd3:    seg_decode = 7'b1001111;
      4'd4:    seg_decode = 7'b1100110;
      4'd5:    seg_decode = 7'b1101101;
      4'd6:    seg_decode = 7'b1111101;
      4'd7:    seg_decode = 7'b0000111;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1101111;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  // Add-3 on every BCD nibble >= 5, then shift the whole register left.
  always_comb begin
    adj = sreg;
    if (sreg[20:17] >= 4'd5) adj[20:17] = sreg[20:17] + 4'd3;
    if (sreg[16:13] >= 4'd5) adj[16:13] = sreg[16:13] + 4'd3;
    if (sreg[12:9]  >= 4'd5) adj[12:9]  = sreg[12:9]  + 4'd3;
    shifted = {adj[19:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_val  <= 9'd0;
      force_cnv <= 1'b1;
      sreg      <= 21'd0;
      iter      <= 4'd0;
      bcd       <= 12'd0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (o_in != last_val || force_cnv) begin
            last_val  <= o_in;
            force_cnv <= 1'b0;
            sreg      <= {12'd0, o_in};
            iter      <= 4'd0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= shifted;
          iter <= iter + 4'd1;
          if (iter == 4'd8) begin
            bcd   <= shifted[20:9];
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= 16'd0;
      digit    <= 2'd0;
    end else if (scan_cnt == 16'(REFRESH_DIV - 1)) begin
      scan_cnt <= 16'd0;
      digit    <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  always_comb begin
    case (digit)
      2'd0:    nib = bcd[3:0];
      2'd1:    nib = bcd[7:4];
      2'd2:    nib = bcd[11:8];
      default: nib = 4'hF;
    endcase
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (digit == 2'd2 && bcd[11:8] == 4'd0) blank = 1'b1;
    if (digit == 2'd1 && bcd[11:4] == 8'd0) blank = 1'b1;
`endif
    seg_hi = (valid && !blank) ? seg_decode(nib) : 7'b0000000;
    an_hi  = valid ? (3'b001 << digit) : 3'b000;
    seg    = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    an     = SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
  end

endmodule

// File: tb/tb_oreg_display_driver.sv
// Directed bench for oreg_display_driver with a short refresh period.
module tb_oreg_display_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  o_in = 9'd0;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] bcd;
  logic        busy;
  logic        valid;

  int n_chk  = 0;
  int n_pass = 0;

  oreg_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .o_in(o_in), .seg(seg), .an(an),
    .bcd(bcd), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge 0 starts the conversion; result must appear exactly at edge 9.
  task automatic convert(input logic [8:0] v, input logic [11:0] exp);
    int busy_ok;
    o_in = v;
    tick();
    chk("start_busy", busy, 1);
    busy_ok = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (!busy) busy_ok = 0;
    end
    chk("busy_held", busy_ok, 1);
    chk("bcd_before_done_vs_old", (bcd == exp && exp != bcd) ? 1 : 0, 0);
    tick();
    chk("bcd", bcd, exp);
    chk("valid", valid, 1);
    chk("busy_done", busy, 0);
  endtask

  task automatic wait_slot(input logic [2:0] target);
    int n = 0;
    while (an == target && n < 64) begin tick(); n++; end
    while (an != target && n < 64) begin tick(); n++; end
    if (n >= 64) chk("slot_timeout", 0, 1);
  endtask

  localparam logic [6:0] S0 = ~7'b0111111;
  localparam logic [6:0] S2 = ~7'b1011011;
  localparam logic [6:0] S4 = ~7'b1100110;
  localparam logic [6:0] SB = 7'b1111111;

  initial begin
    int ok;
    logic [6:0] hund_exp;
    // Reset state
    #2;
    chk("rst_bcd", bcd, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_an", an, 3'b111);
    chk("rst_seg", seg, SB);
    #10 rst = 1'b1;
    // force conversion of o_in=0
    convert(9'd0, 12'h000);
    tick();
    chk("idle_stays", busy, 0);

    convert(9'd2, 12'h002);
    wait_slot(3'b110);
    chk("ones_seg_2", seg, S2);

    convert(9'd511, 12'h511);
    convert(9'd100, 12'h100);

    // o_in changes mid-conversion: old value completes, new one follows at edge 10
    o_in = 9'd123;
    tick();
    repeat (4) tick();
    o_in = 9'd456;
    repeat (5) tick();
    chk("midchg_bcd1", bcd, 12'h123);
    chk("midchg_busy9", busy, 0);
    tick();
    chk("midchg_busy10", busy, 1);
    repeat (9) tick();
    chk("midchg_bcd2", bcd, 12'h456);

    convert(9'd42, 12'h042);
`ifdef LEADING_ZERO_BLANK_EN
    hund_exp = SB;
`else
    hund_exp = S0;
`endif
    wait_slot(3'b110);
    ok = 1;
    for (int i = 0; i < 12; i++) begin
      case (i / 4)
        0: if (an !== 3'b110 || seg !== S2) ok = 0;
        1: if (an !== 3'b101 || seg !== S4) ok = 0;
        default: if (an !== 3'b011 || seg !== hund_exp) ok = 0;
      endcase
      if (i == 8) chk("hund_seg", seg, hund_exp);
      tick();
    end
    chk("scan_sequence", ok, 1);
    chk("scan_wrap_ones", an, 3'b110);

    // Reset mid-conversion
    o_in = 9'd77;
    tick();
    repeat (5) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("arst_bcd", bcd, 0);
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_an", an, 3'b111);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1);
    repeat (8) tick();
    chk("post_rst_pending", valid, 0);
    tick();
    chk("post_rst_bcd", bcd, 12'h077);
    chk("post_rst_valid", valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
